// File: rtl/instr_fetch.sv
// ============================================================================
// Module   : instr_fetch
// Purpose  : Instruction fetch stage. Owns the PC, keeps at most one memory
//            request in flight and buffers {pc, instr} pairs for the decoder.
//            The misaligned-redirect halt is built only when the macro
//            FETCH_MISALIGN_CHECK_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        dec_ready,
    output logic        misalign_err
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_HALT  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [31:0]      req_addr_q, req_addr_d;
    logic             pend_q, pend_d;
    logic             halt_after_q, halt_after_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [31:0]      pc_mem_q    [FIFO_DEPTH];
    logic [31:0]      instr_mem_q [FIFO_DEPTH];

    logic [31:0]      w_target;
    logic             w_misalign;
    logic             w_full;
    logic             w_push;
    logic             w_pop;

`ifdef FETCH_MISALIGN_CHECK_EN
    assign w_target   = redirect_pc;
    assign w_misalign = redirect && (redirect_pc[1:0] != 2'b00);
`else
    // Low bits are masked rather than dropped so the port stays fully used.
    assign w_target   = {redirect_pc[31:2], redirect_pc[1:0] & 2'b00};
    assign w_misalign = 1'b0;
`endif

    assign w_full       = (count_q == CNT_W'(FIFO_DEPTH));
    assign imem_req     = !rst && ((state_q == ST_DRAIN) ||
                                   ((state_q == ST_FETCH) && (!w_full || pend_q)));
    assign imem_addr    = pend_q ? req_addr_q : fetch_pc_q;
    assign if_valid     = (count_q != '0);
    assign if_instr     = instr_mem_q[rd_ptr_q];
    assign if_pc        = pc_mem_q[rd_ptr_q];
    assign misalign_err = err_q;

    assign w_push = (state_q == ST_FETCH) && imem_req && imem_ack && !redirect;
    assign w_pop  = if_valid && dec_ready && !redirect;

    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        halt_after_d = halt_after_q;
        err_d        = err_q;
        count_d      = count_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        pend_d       = imem_req && !imem_ack;
        req_addr_d   = imem_addr;

        case (state_q)
            ST_FETCH: begin
                if (redirect) begin
                    count_d    = '0;
                    rd_ptr_d   = '0;
                    wr_ptr_d   = '0;
                    fetch_pc_d = w_target;
                    if (w_misalign) begin
                        err_d = 1'b1;
                    end
                    // An unacked request must be drained before anything else.
                    if (imem_req && !imem_ack) begin
                        state_d      = ST_DRAIN;
                        halt_after_d = w_misalign;
                    end else if (w_misalign) begin
                        state_d = ST_HALT;
                    end
                end else begin
                    if (w_push) begin
                        fetch_pc_d = fetch_pc_q + 32'd4;
                        wr_ptr_d   = wr_ptr_q + PTR_W'(1);
                    end
                    if (w_pop) begin
                        rd_ptr_d = rd_ptr_q + PTR_W'(1);
                    end
                    case ({w_push, w_pop})
                        2'b10:   count_d = count_q + CNT_W'(1);
                        2'b01:   count_d = count_q - CNT_W'(1);
                        default: count_d = count_q;
                    endcase
                end
            end
            ST_DRAIN: begin
                if (redirect) begin
                    fetch_pc_d = w_target;
                    if (w_misalign) begin
                        err_d        = 1'b1;
                        halt_after_d = 1'b1;
                    end
                end
                if (imem_ack) begin
                    state_d = halt_after_d ? ST_HALT : ST_FETCH;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_FETCH;
            fetch_pc_q   <= RESET_PC;
            req_addr_q   <= RESET_PC;
            pend_q       <= 1'b0;
            halt_after_q <= 1'b0;
            err_q        <= 1'b0;
            count_q      <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            req_addr_q   <= req_addr_d;
            pend_q       <= pend_d;
            halt_after_q <= halt_after_d;
            err_q        <= err_d;
            count_q      <= count_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                pc_mem_q[i]    <= 32'h0;
                instr_mem_q[i] <= 32'h0;
            end
        end else if (w_push) begin
            pc_mem_q[wr_ptr_q]    <= fetch_pc_q;
            instr_mem_q[wr_ptr_q] <= imem_rdata;
        end
    end

endmodule

`default_nettype wire

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage, directly upstream of the instruction decoder. It owns the program counter, issues single-outstanding requests to instruction memory, and buffers returned words with their PCs in a small FIFO. The FIFO drives the decoder through a valid/ready handshake. Control-flow redirects from execute (taken branch, JAL, JALR) flush the buffer and restart fetch at the new target.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- FIFO_DEPTH, 2, buffer entries; power of two, ≥2
- clk  in  1  sole clock, rising edge
- rst  in  1  reset; one clock; reset is synchronous and active-high
- imem_req  out  1  fetch request; once high, held with stable imem_addr until imem_ack
- imem_addr  out  32  word-aligned fetch address
- imem_ack  in  1  request accepted; imem_rdata valid in this cycle; may arrive in the same cycle as the request
- imem_rdata  in  32  instruction word
- redirect  in  1  one-cycle pulse: discard everything, fetch from redirect_pc
- redirect_pc  in  32  redirect target
- if_valid  out  1  FIFO head valid
- if_instr  out  32  instruction word at FIFO head
- if_pc  out  32  PC of if_instr
- dec_ready  in  1  decoder accepts head; pop when if_valid && dec_ready
- misalign_err  out  1  sticky misaligned-redirect flag (see Configuration)

## Operation
- State: fetch_pc (32 b), FIFO of {pc, instr} with count 0..FIFO_DEPTH, FSM {FETCH, DRAIN, HALT}.
- FETCH: imem_req = (count < FIFO_DEPTH) || a request is already pending. Once imem_req is raised, it stays high with the same imem_addr until ack, even if the FIFO fills meanwhile. imem_addr = fetch_pc.
- On ack in FETCH: push {fetch_pc, imem_rdata}; fetch_pc += 4 (32-bit wrap, 0xFFFF_FFFC → 0).
- Only one request is ever outstanding, and pushes occur only from an ack. A request raised with count < FIFO_DEPTH therefore always has room on ack.
- Simultaneous push and pop: count unchanged, order preserved.
- Redirect priority overrides push and pop in the same cycle:
  - FIFO cleared (count = 0) and fetch_pc = redirect_pc.
  - If imem_req is high without ack this cycle, enter DRAIN: keep imem_req/imem_addr stable, discard the word on ack, then return to FETCH.
  - If ack coincides with redirect, the word is discarded and no DRAIN is needed.
- DRAIN: a further redirect only updates fetch_pc (latest target wins). There is no pop in DRAIN since the FIFO is empty.
- HALT: entered only under the Configuration feature. imem_req = 0, FIFO empty, if_valid = 0; exit by reset only.

## Timing
- Reset values: imem_req 0, imem_addr RESET_PC, if_valid 0, if_instr 0, if_pc 0, misalign_err 0, count 0, FSM FETCH, fetch_pc RESET_PC.
- First cycle after rst falls: imem_req = 1, imem_addr = RESET_PC.
- Latency: ack at edge N → if_valid high from cycle N+1 (registered FIFO, no bypass).
- Throughput: with zero-wait memory (ack in the request cycle) and dec_ready held high, one instruction per cycle sustained.
- Redirect at edge N → if_valid = 0 in cycle N+1. The request at redirect_pc is issued in cycle N+1 (no pending request) or in the cycle after the draining ack.
- If_instr/if_pc hold while if_valid && !dec_ready.
- rst asserted mid-operation, including DRAIN, returns everything to reset values at the next edge. The memory side must tolerate an abandoned request.

## Configuration
- FETCH_MISALIGN_CHECK_EN defined:
  - A redirect with redirect_pc[1:0] != 2'b00 sets misalign_err (sticky until reset), clears the FIFO and enters HALT instead of FETCH or DRAIN.
  - If a request is pending, the FSM drains it first, then halts.
- Undefined: redirect_pc[1:0] is ignored (forced to 00). misalign_err is tied 0.

## Test plan
- Reset release, zero-wait memory returning addr^32'hA5A5_0000, dec_ready = 1 → imem_addr 0, 4, 8 … on consecutive cycles. if_pc tracks them one cycle later, one instruction per cycle.
- dec_ready = 0 for 6 cycles → exactly FIFO_DEPTH (2) words buffered and imem_req low. dec_ready = 1 → words at PCs 0, 4 emitted in order, then fetch resumes at 8.
- Memory ack delayed 3 cycles, redirect to 0x100 in cycle 1 of the wait → addr held until ack, word discarded, next imem_addr 0x100, first if_pc 0x100.
- Redirect to 0x200 coincident with ack and pop → no push, if_valid 0 next cycle, imem_addr 0x200 the next cycle.
- RESET_PC = 0xFFFF_FFF8 → fetch addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- With FETCH_MISALIGN_CHECK_EN, redirect to 0x102 → misalign_err = 1, imem_req stays 0 until rst. Without the macro → fetch from 0x100, misalign_err 0.
